shift_reg_univ: RTL and testbench

Parametrised universal shift register with an automatic serialiser. Holds a WIDTH-bit word and supports hold, shift-left, shift-right and parallel load under a mode select. A start pulse also loads a word and shifts it out LSB-first with busy/done status. It is the sequential successor to the team's single-bit latch/flop storage cells and the common building block for serial links and bit-level datapaths.

---
 rtl/shift_reg_pkg.sv | 26 ++
 rtl/shift_cell.sv | 44 ++++
 rtl/shift_reg_univ.sv | 114 +++++++++++
 tb/tb_shift_reg_univ.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: manual mode select,
// transfer FSM states and the per-bit next-value select of shift_cell.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    // CSEL_LO takes the lower-index neighbour (shift left),
    // CSEL_HI takes the higher-index neighbour (shift right).
    typedef enum logic [1:0] {
        CSEL_HOLD = 2'b00,
        CSEL_LO   = 2'b01,
        CSEL_HI   = 2'b10,
        CSEL_LOAD = 2'b11
    } cell_sel_e;

endpackage

// File: rtl/shift_cell.sv
// One storage bit of the universal shift register: 4:1 next-value mux
// (hold, lower neighbour, higher neighbour, load bit), enable and an
// asynchronous reset value.
module shift_cell
    import shift_reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en_i,
    input  cell_sel_e sel_i,
    input  logic      lo_i,
    input  logic      hi_i,
    input  logic      d_i,
    output logic      q_o
);

    logic bit_q;
    logic bit_d;

    // Select the next value of this bit.
    always_comb begin
        bit_d = bit_q;
        case (sel_i)
            CSEL_LO:   bit_d = lo_i;
            CSEL_HI:   bit_d = hi_i;
            CSEL_LOAD: bit_d = d_i;
            default:   bit_d = bit_q;
        endcase
    end

    // Bit storage, frozen while the enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q <= RESET_BIT;
        end else if (en_i) begin
            bit_q <= bit_d;
        end
    end

    assign q_o = bit_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift-left / shift-right / load) with an
// automatic LSB-first serialiser started by a start pulse.
// Optional macro SHIFT_REG_ROTATE_EN: manual SHL/SHR rotate instead of
// shifting in sin; serial transfers always shift sin in.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 2);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    cell_sel_e          sel;
    logic               fill_lo;
    logic               fill_hi;
    logic [WIDTH-1:0]   lo_v;
    logic [WIDTH-1:0]   hi_v;

    // Next state, counter, done pulse, cell select and edge fill bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sel     = CSEL_HOLD;
        fill_lo = sin;
        fill_hi = sin;
        case (state_q)
            ST_IDLE: begin
`ifdef SHIFT_REG_ROTATE_EN
                fill_lo = q[WIDTH-1];
                fill_hi = q[0];
`endif
                if (start) begin
                    sel     = CSEL_LOAD;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    case (mode_e'(mode))
                        MODE_SHL:  sel = CSEL_LO;
                        MODE_SHR:  sel = CSEL_HI;
                        MODE_LOAD: sel = CSEL_LOAD;
                        default:   sel = CSEL_HOLD;
                    endcase
                end
            end
            ST_XFER: begin
                sel = CSEL_HI;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counter and done registers; all frozen while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign lo_v = {q[WIDTH-2:0], fill_lo};
    assign hi_v = {fill_hi, q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .en_i  (en),
            .sel_i (sel),
            .lo_i  (lo_v[i]),
            .hi_i  (hi_v[i]),
            .d_i   (d[i]),
            .q_o   (q[i])
        );
    end

    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];
    assign busy     = (state_q == ST_XFER);
    assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, RESET_VAL=0).
// Expected values follow SHIFT_REG_ROTATE_EN when it is defined.
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [7:0] q;
    logic       sout_lsb;
    logic       sout_msb;
    logic       busy;
    logic       done;

    int chk_cnt = 0;
    int err_cnt = 0;

    shift_reg_univ #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .sin      (sin),
        .start    (start),
        .q        (q),
        .sout_lsb (sout_lsb),
        .sout_msb (sout_msb),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = clk_run ? ~clk : clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer of dv; en is dropped on edges stall_e and stall_e+1
    // (stall_e=0: no stall). A start/LOAD is pulsed on edge 3 and must be ignored.
    task automatic run_xfer(input logic [7:0] dv, input int stall_e,
                            output int busy_cyc, output logic [7:0] bits,
                            output int done_cyc);
        int nb;
        en = 1'b1; mode = MODE_HOLD; d = dv; start = 1'b1;
        step();
        start = 1'b0; d = 8'h00;
        busy_cyc = 0; done_cyc = 0; bits = '0;
        if (busy) busy_cyc++;
        if (done) done_cyc++;
        bits[0] = sout_lsb;
        nb = 1;
        for (int e = 1; e < 20 && busy; e++) begin
            en = !(stall_e > 0 && (e == stall_e || e == stall_e + 1));
            if (e == 3) begin
                start = 1'b1; mode = MODE_LOAD; d = 8'h00;
            end else begin
                start = 1'b0; mode = MODE_HOLD;
            end
            step();
            if (en && nb < 8) begin
                bits[nb] = sout_lsb;
                nb++;
            end
            if (busy) busy_cyc++;
            if (done) done_cyc++;
        end
        check("xfer_terminates", 32'(busy), 32'd0);
        en = 1'b1; start = 1'b0; mode = MODE_HOLD;
        step();
        if (done) done_cyc++;
    endtask

    int         bc;
    int         dc;
    logic [7:0] bits;

    initial begin
        rst = 1'b0; en = 1'b0; mode = MODE_HOLD; d = 8'h00; sin = 1'b0; start = 1'b0;
        #2;
        // asynchronous reset with the clock stopped
        rst = 1'b1;
        #3;
        check("rst_q", 32'(q), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lsb", 32'(sout_lsb), 32'd0);
        rst = 1'b0;
        #2;
        clk_run = 1'b1;

        // LOAD then SHL with sin=1
        en = 1'b1; mode = MODE_LOAD; d = 8'hA5;
        step();
        check("load_a5", 32'(q), 32'hA5);
        mode = MODE_SHL; sin = 1'b1;
        step();
        check("shl1", 32'(q), 32'h4B);
        step();
`ifdef SHIFT_REG_ROTATE_EN
        check("shl2", 32'(q), 32'h96);
        check("shl2_msb", 32'(sout_msb), 32'd1);
        step();
        check("shl3", 32'(q), 32'h2D);
`else
        check("shl2", 32'(q), 32'h97);
        check("shl2_msb", 32'(sout_msb), 32'd1);
        step();
        check("shl3", 32'(q), 32'h2F);
`endif

        // LOAD then SHR with sin=0
        mode = MODE_LOAD; d = 8'h81; sin = 1'b0;
        step();
        check("load_81", 32'(q), 32'h81);
        mode = MODE_SHR;
        step();
`ifdef SHIFT_REG_ROTATE_EN
        check("shr1", 32'(q), 32'hC0);
        step();
        check("shr2", 32'(q), 32'h60);
`else
        check("shr1", 32'(q), 32'h40);
        step();
        check("shr2", 32'(q), 32'h20);
`endif

        // en low freezes q even with LOAD requested
        en = 1'b0; mode = MODE_LOAD; d = 8'hFF;
        step();
`ifdef SHIFT_REG_ROTATE_EN
        check("en0_load", 32'(q), 32'h60);
`else
        check("en0_load", 32'(q), 32'h20);
`endif
        en = 1'b1; mode = MODE_HOLD;

        // plain transfer of 0xB2, sin=1 fills the top
        sin = 1'b1;
        run_xfer(8'hB2, 0, bc, bits, dc);
        check("xfer_busy_cycles", 32'(bc), 32'd7);
        check("xfer_bits", 32'(bits), 32'hB2);
        check("xfer_done_pulses", 32'(dc), 32'd1);
        check("xfer_q_final", 32'(q), 32'hFF);

        // transfer with two stalled cycles
        run_xfer(8'hB2, 4, bc, bits, dc);
        check("stall_busy_cycles", 32'(bc), 32'd9);
        check("stall_bits", 32'(bits), 32'hB2);
        check("stall_done_pulses", 32'(dc), 32'd1);

        // reset asserted during the 4th transfer cycle
        en = 1'b1; mode = MODE_HOLD; d = 8'hB2; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        check("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_q", 32'(q), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        #1;
        rst = 1'b0;
        step();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // next transfer after the abort works normally
        run_xfer(8'h3C, 0, bc, bits, dc);
        check("after_busy_cycles", 32'(bc), 32'd7);
        check("after_bits", 32'(bits), 32'h3C);
        check("after_done_pulses", 32'(dc), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
